ring_decoder: RTL and testbench

//  Receive-side checker/decoder for a one-hot ring bus (the ringcounter output).
//  - Samples the ring word each clock and converts it to a binary index.
//  - Confirms the ring only holds or advances one position per cycle.
//  - Pulses on every step and every wrap, and counts laps.
//  - Latches a sticky error on any illegal word or illegal transition.
//  - Sits between a ringcounter (e.g. display digit scan) and logic needing a binary slot number plus a health flag.

---
 rtl/ring_decoder_if.sv | 27 ++
 rtl/ring_decoder.sv | 113 +++++++++++
 tb/tb_ring_decoder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ring_decoder_if.sv
// Bundle of the ring word, the clear request and the decoded status outputs.
// The master drives the ring and clear; the slave (the decoder) drives the status.
interface ring_decoder_if #(
  parameter int unsigned width_p     = 10,
  parameter int unsigned lap_width_p = 8
);
  localparam int unsigned idx_w = $clog2(width_p);

  logic [width_p-1:0]     ring;
  logic                   clear;
  logic [idx_w-1:0]       index;
  logic                   valid;
  logic                   step;
  logic                   wrap;
  logic [lap_width_p-1:0] lap_count;
  logic                   error;

  modport master (
    output ring, clear,
    input  index, valid, step, wrap, lap_count, error
  );

  modport slave (
    input  ring, clear,
    output index, valid, step, wrap, lap_count, error
  );
endinterface

// File: rtl/ring_decoder.sv
// One-hot ring bus checker: converts the ring word to a binary index, checks that the
// ring only holds or advances by one, pulses on step/wrap, counts laps, flags faults.
module ring_decoder #(
  parameter int unsigned width_p     = 10,
  parameter int unsigned lap_width_p = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  ring_decoder_if.slave bus_io
);
  localparam int unsigned idx_w = $clog2(width_p);
  localparam int unsigned cnt_w = $clog2(width_p + 1);
  localparam logic [idx_w-1:0] last_idx = idx_w'(width_p - 1);

  typedef enum logic [1:0] {StAcquire, StTrack, StFault} state_e;

  state_e                 state_q, state_d;
  logic [idx_w-1:0]       idx_q, idx_d;
  logic                   step_q, step_d;
  logic                   wrap_q, wrap_d;
  logic [lap_width_p-1:0] lap_q, lap_d;
  logic                   err_q, err_d;

  logic [cnt_w-1:0] ones;
  logic [idx_w-1:0] enc;
  logic             legal;
  logic [idx_w-1:0] next_pos;

  always_comb begin
    ones = '0;
    enc  = '0;
    for (int unsigned i = 0; i < width_p; i++) begin
      if (bus_io.ring[i]) begin
        ones = ones + 1'b1;
        enc  = idx_w'(i);
      end
    end
  end

  assign legal    = (ones == cnt_w'(1));
  // Successor modulo width_p; width_p need not be a power of two.
  assign next_pos = (idx_q == last_idx) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    lap_d   = lap_q;
    err_d   = err_q;

    if (bus_io.clear) begin
      state_d = StAcquire;
      err_d   = 1'b0;
      lap_d   = '0;
    end else begin
      unique case (state_q)
        StAcquire: begin
          if (legal) begin
            idx_d   = enc;
            state_d = StTrack;
          end
        end
        StTrack: begin
          if (legal && (enc == idx_q)) begin
            state_d = StTrack;
          end else if (legal && (enc == next_pos)) begin
            step_d = 1'b1;
            idx_d  = enc;
            if (idx_q == last_idx) begin
              wrap_d = 1'b1;
              lap_d  = lap_q + 1'b1;
            end
          end else begin
            state_d = StFault;
            err_d   = 1'b1;
          end
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StAcquire;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StAcquire;
      idx_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      lap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      lap_q   <= lap_d;
      err_q   <= err_d;
    end
  end

  assign bus_io.index     = idx_q;
  assign bus_io.valid     = (state_q == StTrack);
  assign bus_io.step      = step_q;
  assign bus_io.wrap      = wrap_q;
  assign bus_io.lap_count = lap_q;
  assign bus_io.error     = err_q;
endmodule

// File: tb/tb_ring_decoder.sv
// Bench for ring_decoder: directed scenarios plus random traffic, all checked
// against a behavioural model of the ring decoding rules.
module tb_ring_decoder;
  localparam int unsigned W  = 10;
  localparam int unsigned LW = 8;
  localparam int unsigned ModeAcq   = 0;
  localparam int unsigned ModeTrack = 1;
  localparam int unsigned ModeFault = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ring_decoder_if #(.width_p(W), .lap_width_p(LW)) bus ();

  ring_decoder #(.width_p(W), .lap_width_p(LW)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned m_mode = ModeAcq;
  int unsigned m_idx  = 0;
  int unsigned m_lap  = 0;
  bit          m_err  = 1'b0;
  bit          m_step = 1'b0;
  bit          m_wrap = 1'b0;
  int unsigned wraps_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] onehot(input int unsigned i);
    logic [W-1:0] w;
    w    = '0;
    w[i] = 1'b1;
    return w;
  endfunction

  task automatic model_step(input bit r, input bit c, input logic [W-1:0] word);
    int unsigned pos;
    int unsigned n;
    m_step = 1'b0;
    m_wrap = 1'b0;
    if (r) begin
      m_mode = ModeAcq; m_idx = 0; m_lap = 0; m_err = 1'b0;
    end else if (c) begin
      m_mode = ModeAcq; m_lap = 0; m_err = 1'b0;
    end else begin
      n   = $countones(word);
      pos = 0;
      for (int i = 0; i < W; i++) if (word[i]) pos = i;
      if (m_mode == ModeAcq) begin
        if (n == 1) begin
          m_idx  = pos;
          m_mode = ModeTrack;
        end
      end else if (m_mode == ModeTrack) begin
        if (n == 1 && pos == m_idx) begin
          m_mode = ModeTrack;
        end else if (n == 1 && pos == (m_idx + 1) % W) begin
          m_step = 1'b1;
          if (pos == 0) begin
            m_wrap = 1'b1;
            m_lap  = (m_lap + 1) % (1 << LW);
          end
          m_idx = pos;
        end else begin
          m_mode = ModeFault;
          m_err  = 1'b1;
        end
      end
    end
  endtask

  task automatic apply(input logic [W-1:0] word, input bit c, input bit r);
    rst       = r;
    bus.clear = c;
    bus.ring  = word;
    @(posedge clk);
    #1;
    model_step(r, c, word);
    wraps_seen += 32'(bus.wrap);
    check("index", 32'(bus.index), m_idx);
    check("valid", 32'(bus.valid), 32'(m_mode == ModeTrack));
    check("step", 32'(bus.step), 32'(m_step));
    check("wrap", 32'(bus.wrap), 32'(m_wrap));
    check("lap", 32'(bus.lap_count), m_lap);
    check("error", 32'(bus.error), 32'(m_err));
  endtask

  task automatic rotate(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) apply(onehot((m_idx + 1) % W), 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] w;
    int unsigned  r;
    rst       = 1'b1;
    bus.clear = 1'b0;
    bus.ring  = '0;

    apply('0, 1'b0, 1'b1);
    apply('0, 1'b0, 1'b1);

    // Scenario 1: acquire at 0, rotate once around.
    apply(onehot(0), 1'b0, 1'b0);
    check("acq_valid", 32'(bus.valid), 32'd1);
    rotate(10);
    check("rot_idx", 32'(bus.index), 32'd0);

    // Scenario 2: 25 laps, then 256 laps roll the counter over.
    apply('0, 1'b0, 1'b1);
    apply(onehot(0), 1'b0, 1'b0);
    wraps_seen = 0;
    rotate(250);
    check("wraps25", wraps_seen, 32'd25);
    check("lap25", 32'(bus.lap_count), 32'd25);
    apply('0, 1'b0, 1'b1);
    apply(onehot(0), 1'b0, 1'b0);
    rotate(2560);
    check("lap256", 32'(bus.lap_count), 32'd0);

    // Scenario 3: hold then step.
    apply(onehot(0), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply(onehot(3), 1'b0, 1'b0);
    check("hold_idx", 32'(bus.index), 32'd3);
    check("hold_step", 32'(bus.step), 32'd0);
    apply(onehot(4), 1'b0, 1'b0);
    check("step_after_hold", 32'(bus.step), 32'd1);

    // Scenario 4: skip, empty word and double-bit word all fault from index 2.
    for (int k = 0; k < 3; k++) begin
      apply(onehot(0), 1'b1, 1'b0);
      apply(onehot(2), 1'b0, 1'b0);
      w = (k == 0) ? onehot(4) : (k == 1) ? '0 : W'(10'b0000000110);
      apply(w, 1'b0, 1'b0);
      check("fault_err", 32'(bus.error), 32'd1);
      check("fault_valid", 32'(bus.valid), 32'd0);
      apply(onehot(3), 1'b0, 1'b0);
      check("fault_sticky", 32'(bus.error), 32'd1);
    end

    // Scenario 5: clear out of fault, then re-acquire.
    apply(onehot(0), 1'b1, 1'b0);
    check("clr_err", 32'(bus.error), 32'd0);
    apply(onehot(1), 1'b0, 1'b0);
    check("reacq_idx", 32'(bus.index), 32'd1);

    // Scenario 6: reset mid-lap.
    apply('0, 1'b0, 1'b1);
    apply(onehot(0), 1'b0, 1'b0);
    rotate(36);
    check("pre_rst_lap", 32'(bus.lap_count), 32'd3);
    apply(onehot(7), 1'b0, 1'b1);
    check("rst_idx", 32'(bus.index), 32'd0);
    apply(onehot(1), 1'b0, 1'b0);
    check("post_rst_idx", 32'(bus.index), 32'd1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      apply(onehot((m_idx + 1) % W), 1'b0, 1'b0);
      else if (r < 80) apply(onehot(m_idx), 1'b0, 1'b0);
      else if (r < 88) apply(W'($urandom), 1'b0, 1'b0);
      else if (r < 97) apply(W'($urandom), 1'b1, 1'b0);
      else             apply(W'($urandom), 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
